// File: rtl/count_en_if.sv
// count_en_if: control/status bundle for count_en_gen
//   start, stop  run control levels sampled on clk
//   mode, div, burst  run configuration, captured when a run is accepted
//   en, busy, done  enable pulse and run status
interface count_en_if;
   logic       start;
   logic       stop;
   logic       mode;
   logic [7:0] div;
   logic [3:0] burst;
   logic       en;
   logic       busy;
   logic       done;
   modport master (output start, stop, mode, div, burst, input en, busy, done);
   modport slave  (input start, stop, mode, div, burst, output en, busy, done);
endinterface

// File: rtl/count_en_gen.sv
// count_en_gen: prescaled enable-pulse generator with continuous and burst runs
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  count_en_if.slave: start/stop/mode/div/burst in, en/busy/done out
module count_en_gen (
   input  logic        clk,
   input  logic        rst,
   count_en_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t     state, state_n;
   logic       en_q, en_n;
   logic [7:0] pre, pre_n, div_r, div_n;
   logic [4:0] rem, rem_n;
   logic       mode_r, mode_n;
   always_comb begin
      state_n = state;
      en_n    = 1'b0;
      pre_n   = pre;
      rem_n   = rem;
      div_n   = div_r;
      mode_n  = mode_r;
      case (state)
         IDLE: if (bus.start && !bus.stop) begin
            state_n = RUN;
            pre_n   = bus.div;
            div_n   = bus.div;
            mode_n  = bus.mode;
            rem_n   = (bus.burst == 4'd0) ? 5'd16 : {1'b0, bus.burst};
         end
         RUN: if (bus.stop) begin
            state_n = DONE;
         end else if (pre == 8'd0) begin
            en_n  = 1'b1;
            pre_n = div_r;
            // the final burst pulse lands in the same period as done
            if (mode_r) begin
               rem_n   = rem - 5'd1;
               state_n = (rem == 5'd1) ? DONE : RUN;
            end
         end else begin
            pre_n = pre - 8'd1;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         en_q   <= 1'b0;
         pre    <= 8'd0;
         rem    <= 5'd0;
         div_r  <= 8'd0;
         mode_r <= 1'b0;
      end else begin
         state  <= state_n;
         en_q   <= en_n;
         pre    <= pre_n;
         rem    <= rem_n;
         div_r  <= div_n;
         mode_r <= mode_n;
      end
   end
   assign bus.en   = en_q;
   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
endmodule

// File: tb/tb_count_en_gen.sv
// tb_count_en_gen: directed self-checking bench for count_en_gen
module tb_count_en_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   count_en_if bus();
   count_en_gen dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_check(input string tag);
      check({tag, " en"}, bus.en, 1'b0);
      check({tag, " busy"}, bus.busy, 1'b0);
      check({tag, " done"}, bus.done, 1'b0);
   endtask
   // start a run and check en/done/busy for ncyc periods after the start edge;
   // disturb rewrites config and re-pulses start mid-run
   task automatic run(input logic m, input logic [7:0] d, input logic [3:0] b,
                      input int ncyc, input bit disturb);
      int p, last;
      p = int'(d) + 1;
      last = m ? p * ((b == 4'd0) ? 16 : int'(b)) : (1 << 30);
      bus.mode = m;
      bus.div = d;
      bus.burst = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy at start", bus.busy, 1'b1);
      for (int k = 1; k <= ncyc; k++) begin
         if (disturb && k == 2) begin
            bus.div = 8'd7;
            bus.burst = 4'd1;
            bus.mode = 1'b0;
            bus.start = 1'b1;
         end
         if (disturb && k == 3) bus.start = 1'b0;
         tick();
         check($sformatf("en k=%0d div=%0d", k, d), bus.en, (k % p == 0) && (k <= last));
         check($sformatf("done k=%0d div=%0d", k, d), bus.done, k == last);
         check($sformatf("busy k=%0d div=%0d", k, d), bus.busy, k < last);
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.mode = 1'b0;
      bus.div = 8'd0;
      bus.burst = 4'd0;
      #2 rst = 1'b1;
      #1 idle_check("reset");
      tick();
      rst = 1'b0;
      run(1'b1, 8'd3, 4'd4, 20, 1'b0);
      run(1'b1, 8'd1, 4'd0, 36, 1'b0);
      run(1'b1, 8'd2, 4'd3, 12, 1'b1);
      bus.div = 8'd0;
      run(1'b0, 8'd0, 4'd0, 5, 1'b0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("stop en", bus.en, 1'b0);
      check("stop done", bus.done, 1'b1);
      check("stop busy", bus.busy, 1'b0);
      tick();
      idle_check("after stop");
      tick();
      idle_check("idle hold");
      bus.start = 1'b1;
      bus.stop = 1'b1;
      tick();
      idle_check("start+stop");
      bus.start = 1'b0;
      bus.stop = 1'b0;
      tick();
      idle_check("start+stop next");
      run(1'b0, 8'd5, 4'd0, 18, 1'b0);
      #2 rst = 1'b1;
      #1 idle_check("async rst");
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         idle_check($sformatf("post rst %0d", k));
      end
      run(1'b0, 8'd2, 4'd0, 9, 1'b0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("stop2 done", bus.done, 1'b1);
      check("stop2 en", bus.en, 1'b0);
      tick();
      idle_check("final idle");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
